status_value_vector_tagged: RTL and testbench

//  Parametrised successor of the status value vector: an in-order queue of WIDTH-bit status values.

---
 rtl/status_value_vector_pkg.sv | 19 +
 rtl/svv_wrap_ptr.sv | 23 ++
 rtl/status_value_vector_tagged.sv | 127 ++++++++++++
 tb/tb_status_value_vector_tagged.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/status_value_vector_pkg.sv
// Shared definitions for the tagged status value vector: address-width helper,
// tag/count types for the default depth, and the encoding of the registered error pulses.
package status_value_vector_pkg;

   localparam int SVV_DEFAULT_DEPTH = 32;

   function automatic int svv_aw(input int depth);
      return (depth < 2) ? 1 : $clog2(depth);
   endfunction

   typedef logic [svv_aw(SVV_DEFAULT_DEPTH)-1:0] svv_tag_t;
   typedef logic [svv_aw(SVV_DEFAULT_DEPTH):0]   svv_count_t;

   // One-hot so each pulse output decodes from a single bit pattern.
   localparam logic [1:0] SVV_ERR_NONE      = 2'b00;
   localparam logic [1:0] SVV_ERR_OVERFLOW  = 2'b01;
   localparam logic [1:0] SVV_ERR_UNDERFLOW = 2'b10;

endpackage

// File: rtl/svv_wrap_ptr.sv
// Free-running AW-bit ring pointer with synchronous clear; wraps DEPTH-1 -> 0
// naturally because DEPTH is a power of two.
module svv_wrap_ptr #(
   parameter int AW = 5
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clr,
   input  logic          inc,
   output logic [AW-1:0] ptr
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr <= '0;
      end else if (clr) begin
         ptr <= '0;
      end else if (inc) begin
         ptr <= ptr + AW'(1);
      end
   end

endmodule

// File: rtl/status_value_vector_tagged.sv
// In-order queue of status values; each push is tagged with its slot so the entry can be
// rewritten until it drains. Optional same-cycle bypass on empty under macro SVV_BYPASS_EN.
module status_value_vector_tagged
   import status_value_vector_pkg::*;
#(
   parameter  int DEPTH     = 32,
   parameter  int WIDTH     = 4,
   parameter  int AFULL_THR = 28,
   localparam int AW        = svv_aw(DEPTH)
) (
   input  logic             clk_i,
   input  logic             rsn_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] value_i,
   output logic [AW-1:0]    push_tag_o,
   input  logic             pull_i,
   output logic [WIDTH-1:0] value_o,
   output logic             valid_o,
   input  logic             set_i,
   input  logic [AW-1:0]    set_tag_i,
   input  logic [WIDTH-1:0] set_value_i,
   output logic             full_o,
   output logic             almost_full_o,
   output logic [AW:0]      count_o,
   output logic             overflow_o,
   output logic             underflow_o
);

   localparam logic [AW:0] CNT_FULL  = (AW+1)'(DEPTH);
   localparam logic [AW:0] CNT_AFULL = (AW+1)'(AFULL_THR);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] vld;
   logic [AW-1:0]    head;
   logic [AW-1:0]    tail;
   logic [AW:0]      count;
   logic [1:0]       err;

   logic empty, full, bypass, bypass_pull;
   logic pull_ok, push_ok, wr_en, set_ok, drop, under;

   assign empty = (count == '0);
   assign full  = (count == CNT_FULL);

`ifdef SVV_BYPASS_EN
   assign bypass = empty & push_i & ~flush_i;
`else
   assign bypass = 1'b0;
`endif

   // Handshake: push/pull/set are single-cycle requests with no ready; acceptance is
   // decided in the same cycle (push needs room or a concurrent pull, pull needs an entry),
   // and a refused push or pull is reported by a one-cycle pulse on the following cycle.
   assign bypass_pull = bypass & pull_i;
   assign pull_ok     = ~flush_i & pull_i & ~empty;
   assign push_ok     = ~flush_i & push_i & (~full | pull_i);
   assign wr_en       = push_ok & ~bypass_pull;
   assign drop        = ~flush_i & push_i & full & ~pull_i;
   assign under       = ~flush_i & pull_i & empty & ~bypass;

   // A set racing the pull of its own slot loses; a set to the slot being pushed is
   // already excluded because that slot's valid bit is still clear.
   assign set_ok = ~flush_i & set_i & vld[set_tag_i] & ~(pull_ok && (set_tag_i == head));

   svv_wrap_ptr #(.AW(AW)) u_head (
      .clk   (clk_i),
      .rst_n (rsn_i),
      .clr   (flush_i),
      .inc   (pull_ok),
      .ptr   (head)
   );

   svv_wrap_ptr #(.AW(AW)) u_tail (
      .clk   (clk_i),
      .rst_n (rsn_i),
      .clr   (flush_i),
      .inc   (push_ok),
      .ptr   (tail)
   );

   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         count <= '0;
         err   <= SVV_ERR_NONE;
      end else if (flush_i) begin
         count <= '0;
         err   <= SVV_ERR_NONE;
      end else begin
         count <= count + (AW+1)'(wr_en) - (AW+1)'(pull_ok);
         if (drop) begin
            err <= SVV_ERR_OVERFLOW;
         end else if (under) begin
            err <= SVV_ERR_UNDERFLOW;
         end else begin
            err <= SVV_ERR_NONE;
         end
      end
   end

   // On a full push+pull head equals tail: the set must land after the clear.
   always_ff @(posedge clk_i or negedge rsn_i) begin
      if (!rsn_i) begin
         vld <= '0;
      end else if (flush_i) begin
         vld <= '0;
      end else begin
         if (pull_ok) vld[head] <= 1'b0;
         if (wr_en)   vld[tail] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (set_ok) mem[set_tag_i] <= set_value_i;
      if (wr_en)  mem[tail]      <= value_i;
   end

   assign valid_o       = ~empty | bypass;
   assign value_o       = bypass ? value_i : (empty ? '0 : mem[head]);
   assign push_tag_o    = tail;
   assign full_o        = full;
   assign almost_full_o = (count >= CNT_AFULL);
   assign count_o       = count;
   assign overflow_o    = (err == SVV_ERR_OVERFLOW);
   assign underflow_o   = (err == SVV_ERR_UNDERFLOW);

endmodule

// File: tb/tb_status_value_vector_tagged.sv
// Directed table-driven bench for status_value_vector_tagged at DEPTH=8, WIDTH=4, AFULL_THR=6,
// plus hand sequences for the same-cycle push/pull on empty and asynchronous reset.
module tb_status_value_vector_tagged;

   localparam int DEPTH     = 8;
   localparam int WIDTH     = 4;
   localparam int AFULL_THR = 6;
   localparam int AW        = 3;

   logic             clk_i = 1'b0;
   logic             rsn_i = 1'b0;
   logic             flush_i = 1'b0;
   logic             push_i = 1'b0;
   logic [WIDTH-1:0] value_i = '0;
   logic [AW-1:0]    push_tag_o;
   logic             pull_i = 1'b0;
   logic [WIDTH-1:0] value_o;
   logic             valid_o;
   logic             set_i = 1'b0;
   logic [AW-1:0]    set_tag_i = '0;
   logic [WIDTH-1:0] set_value_i = '0;
   logic             full_o;
   logic             almost_full_o;
   logic [AW:0]      count_o;
   logic             overflow_o;
   logic             underflow_o;

   status_value_vector_tagged #(
      .DEPTH(DEPTH), .WIDTH(WIDTH), .AFULL_THR(AFULL_THR)
   ) dut (
      .clk_i(clk_i), .rsn_i(rsn_i), .flush_i(flush_i), .push_i(push_i), .value_i(value_i),
      .push_tag_o(push_tag_o), .pull_i(pull_i), .value_o(value_o), .valid_o(valid_o),
      .set_i(set_i), .set_tag_i(set_tag_i), .set_value_i(set_value_i), .full_o(full_o),
      .almost_full_o(almost_full_o), .count_o(count_o), .overflow_o(overflow_o),
      .underflow_o(underflow_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic       fl;
      logic       pu;
      logic [3:0] val;
      logic       pl;
      logic       st;
      logic [2:0] stag;
      logic [3:0] sval;
   } in_t;

   typedef struct packed {
      logic       v;
      logic [3:0] value;
      logic [3:0] cnt;
      logic       full;
      logic       af;
      logic [2:0] tag;
      logic       ovf;
      logic       udf;
   } out_t;

   typedef struct packed {
      in_t  i;
      out_t o;
   } vec_t;

   vec_t vecs[$];
   int   errors = 0;
   int   checks = 0;

   function automatic out_t mk(input int v, input int value, input int cnt, input int tag,
                               input int ovf, input int udf);
      out_t o;
      int   vv;
      vv      = (v != 0) ? value : 0;
      o.v     = (v != 0);
      o.value = vv[3:0];
      o.cnt   = cnt[3:0];
      o.full  = (cnt == DEPTH);
      o.af    = (cnt >= AFULL_THR);
      o.tag   = tag[2:0];
      o.ovf   = (ovf != 0);
      o.udf   = (udf != 0);
      return o;
   endfunction

   function automatic void add(input int fl, input int pu, input int val, input int pl,
                               input int st, input int stag, input int sval, input out_t o);
      vec_t x;
      x.i.fl   = (fl != 0);
      x.i.pu   = (pu != 0);
      x.i.val  = val[3:0];
      x.i.pl   = (pl != 0);
      x.i.st   = (st != 0);
      x.i.stag = stag[2:0];
      x.i.sval = sval[3:0];
      x.o      = o;
      vecs.push_back(x);
   endfunction

   function automatic out_t sample();
      return {valid_o, value_o, count_o, full_o, almost_full_o, push_tag_o,
              overflow_o, underflow_o};
   endfunction

   function automatic int vgen(input int i);
      return (i * 3 + 1) % 16;
   endfunction

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input in_t x);
      flush_i     = x.fl;
      push_i      = x.pu;
      value_i     = x.val;
      pull_i      = x.pl;
      set_i       = x.st;
      set_tag_i   = x.stag;
      set_value_i = x.sval;
   endtask

   // Drive at negedge, clock once, drop inputs, then sample registered state.
   task automatic apply(input vec_t x, input string name);
      @(negedge clk_i);
      drive(x.i);
      @(posedge clk_i);
      #1;
      drive('0);
      #1;
      check(name, sample(), x.o);
   endtask

   initial begin
      // reset, then push 1..8; almost_full from count 6, full at 8
      for (int k = 1; k <= 8; k++) add(0, 1, k, 0, 0, 0, 0, mk(1, 1, k, k % 8, 0, 0));
      add(0, 1, 9, 0, 0, 0, 0, mk(1, 1, 8, 0, 1, 0));
      add(0, 0, 0, 0, 0, 0, 0, mk(1, 1, 8, 0, 0, 0));
      add(0, 1, 9, 1, 0, 0, 0, mk(1, 2, 8, 1, 0, 0));
      for (int k = 1; k <= 8; k++)
         add(0, 0, 0, 1, 0, 0, 0, mk(k < 8, (k <= 6) ? k + 2 : 9, 8 - k, 1, 0, 0));
      // flush on empty, then tags 0..3 = {1,2,3,4}, rewrite tag 2, set to an empty tag
      add(1, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
      for (int k = 1; k <= 4; k++) add(0, 1, k, 0, 0, 0, 0, mk(1, 1, k, k, 0, 0));
      add(0, 0, 0, 0, 1, 2, 10, mk(1, 1, 4, 4, 0, 0));
      add(0, 0, 0, 0, 1, 6, 15, mk(1, 1, 4, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(1, 2, 3, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(1, 10, 2, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(1, 4, 1, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 4, 0, 0));
      // head set visible next cycle; head set racing its pull loses
      add(0, 1, 7, 0, 0, 0, 0, mk(1, 7, 1, 5, 0, 0));
      add(0, 1, 8, 0, 0, 0, 0, mk(1, 7, 2, 6, 0, 0));
      add(0, 0, 0, 0, 1, 4, 3, mk(1, 3, 2, 6, 0, 0));
      add(0, 0, 0, 1, 1, 4, 12, mk(1, 8, 1, 6, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 6, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 6, 0, 1));
      add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 6, 0, 0));
      // five entries across the tag wrap, then flush with push/pull/set
      for (int k = 1; k <= 5; k++) add(0, 1, k, 0, 0, 0, 0, mk(1, 1, k, (6 + k) % 8, 0, 0));
      add(1, 1, 9, 1, 1, 0, 5, mk(0, 0, 0, 0, 0, 0));
      add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
      // flush while full with a push that would otherwise overflow
      for (int k = 1; k <= 8; k++) add(0, 1, k + 8, 0, 0, 0, 0, mk(1, 9, k, k % 8, 0, 0));
      add(1, 1, 5, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
      add(0, 0, 0, 0, 0, 0, 0, mk(0, 0, 0, 0, 0, 0));
      // interleaved push/pull across the 7->0 wrap
      for (int i = 0; i < 3; i++) add(0, 1, vgen(i), 0, 0, 0, 0, mk(1, vgen(0), i + 1, i + 1, 0, 0));
      for (int j = 1; j <= 17; j++)
         add(0, 1, vgen(j + 2), 1, 0, 0, 0, mk(1, vgen(j), 3, (3 + j) % 8, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(1, vgen(18), 2, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(1, vgen(19), 1, 4, 0, 0));
      add(0, 0, 0, 1, 0, 0, 0, mk(0, 0, 0, 4, 0, 0));

      #12;
      check("reset_state", sample(), mk(0, 0, 0, 0, 0, 0));
      @(negedge clk_i);
      rsn_i = 1'b1;

      for (int n = 0; n < vecs.size(); n++) apply(vecs[n], $sformatf("vec%0d", n));

      // push 5 + pull on an empty queue (tail at 4)
      @(negedge clk_i);
      push_i  = 1'b1;
      value_i = 4'h5;
      pull_i  = 1'b1;
      #1;
`ifdef SVV_BYPASS_EN
      check("bypass_same_cycle", {11'd0, valid_o, value_o}, {11'd0, 1'b1, 4'h5});
`else
      check("no_bypass_same_cycle", {11'd0, valid_o, value_o}, 16'd0);
`endif
      @(posedge clk_i);
      #1;
      drive('0);
      #1;
`ifdef SVV_BYPASS_EN
      check("bypass_after", sample(), mk(0, 0, 0, 5, 0, 0));
`else
      check("push_pull_empty_after", sample(), mk(1, 5, 1, 5, 0, 1));
`endif

      // asynchronous reset in the middle of a push burst
      @(negedge clk_i);
      push_i  = 1'b1;
      value_i = 4'h6;
      @(posedge clk_i);
      #2;
      check("pre_reset_nonempty", {15'd0, valid_o}, 16'd1);
      rsn_i = 1'b0;
      #1;
      check("async_reset_immediate", sample(), mk(0, 0, 0, 0, 0, 0));
      push_i = 1'b0;
      @(negedge clk_i);
      @(negedge clk_i);
      check("reset_held", sample(), mk(0, 0, 0, 0, 0, 0));
      rsn_i = 1'b1;
      begin
         vec_t x;
         x   = '0;
         x.i.pu  = 1'b1;
         x.i.val = 4'hB;
         x.o     = mk(1, 11, 1, 1, 0, 0);
         apply(x, "post_reset_push");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
